pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, the successor to the fixed-width ID/EX register. It carries an opaque payload plus the hazard sideband (write address, write enable, tNew, exception code, branch-delay flag) between any two stages. It supports distinct freeze (hold) and bubble-insert stall modes, flush, write squashing, automatic tNew aging, and saturating bubble/flush event counters for performance debug.

## Interface
Parameters:
- DATA_W, 128, payload width (pc, instr, operands, immediate, ...)
- TNEW_W, 5, width of the tNew field
- EXC_W, 5, exception-code width; 0 means no exception
- CNT_W, 16, width of each event counter
- AGE_TNEW, 1, 1 = tnew_out is the input tNew decremented, saturating at 0; 0 = pass through unchanged

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; one clock; sampled only at rising clk
- hold  in  1  freeze: downstream stage stalled, keep current contents
- bubble  in  1  upstream stalled: load a NOP (all-zero) entry
- flush  in  1  kill: load a NOP entry (exception/eret from a later stage)
- valid_in  in  1  upstream entry is a real instruction
- data_in  in  DATA_W  payload
- we_in  in  1  instruction writes GRF
- wa_in  in  5  GRF write address
- tnew_in  in  TNEW_W  cycles until the result is available, as seen upstream
- exc_in  in  EXC_W  exception code
- bd_in  in  1  instruction sits in a branch delay slot
- valid_out, data_out, we_out, wa_out, tnew_out, exc_out, bd_out  out  same widths  registered copies
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating
- flush_cnt  out  CNT_W  flush cycles since reset, saturating

## Operation
- Per-cycle priority: reset > flush > hold > bubble > load.
- reset: every output, including both counters, becomes 0.
- flush: entry becomes NOP (all stage outputs 0); flush_cnt += 1 (saturating). A flush wins over a simultaneous hold.
- hold (no flush): all stage outputs keep their value, tnew_out included (no aging while frozen); counters unchanged. A simultaneous bubble is ignored and not counted.
- bubble (no flush/hold): entry becomes NOP; bubble_cnt += 1 (saturating).
- load: valid_out <= valid_in; data_out, wa_out, exc_out, bd_out <= inputs, each ANDed with valid_in, so an invalid input yields all-zero fields.
- we_out <= we_in & valid_in & (wa_in != 0) & (exc_in == 0). Writes to $0 and writes from excepting instructions are squashed at this point.
- tnew_out <= AGE_TNEW ? (tnew_in == 0 ? 0 : tnew_in - 1) : tnew_in. It is forced to 0 when valid_in = 0.
- A NOP entry is all-zero: valid, we, wa, tnew, exc, bd and data are all 0.
- Counters hold at 2^CNT_W - 1 once reached; they never wrap.

## Timing
- Single-cycle latency: inputs sampled at edge N appear on outputs after edge N. There is no combinational input-to-output path.
- All outputs are 0 from the first edge with reset = 1 until the first edge with reset = 0 that loads or bubbles.
- Reset asserted mid-hold or mid-flush clears everything on that edge. The following edge operates normally.
- hold may stay asserted any number of cycles; contents are bit-identical throughout.
- Back-to-back flushes each count once per cycle.

## Test plan
- Reset: load valid entry (data = 0xDEADBEEF, wa = 5, we = 1, tnew = 2), then reset = 1 with hold = 1 -> every output 0 next cycle, counters 0.
- Load/aging: valid_in = 1, wa = 8, we = 1, tnew_in = 2, exc = 0 -> we_out = 1, wa_out = 8, tnew_out = 1. With tnew_in = 0 -> tnew_out = 0. With AGE_TNEW = 0 and tnew_in = 2 -> tnew_out = 2.
- Squash: wa_in = 0, we_in = 1 -> we_out = 0. wa_in = 9, exc_in = 4 -> we_out = 0, exc_out = 4. valid_in = 0 with data = 0x1234 -> data_out = 0, valid_out = 0.
- Hold vs bubble: entry loaded, then hold = 1 and bubble = 1 for 3 cycles -> outputs unchanged, bubble_cnt = 0. Release hold, keep bubble for 2 cycles -> NOP entry, bubble_cnt = 2.
- Flush priority: hold = 1, flush = 1 on a valid entry -> NOP entry next cycle, flush_cnt = 1. Four consecutive flushes -> flush_cnt = 5.
- Saturation: CNT_W = 2, bubble for 6 cycles -> bubble_cnt reads 1, 2, 3, 3, 3, 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: payload plus hazard sideband,
// with freeze/bubble stalls, flush, write squashing, tNew aging and event counters.
module pipe_stage_reg #(
    parameter int DATA_W   = 128,
    parameter int TNEW_W   = 5,
    parameter int EXC_W    = 5,
    parameter int CNT_W    = 16,
    parameter int AGE_TNEW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              bubble,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we_in,
    input  logic [4:0]        wa_in,
    input  logic [TNEW_W-1:0] tnew_in,
    input  logic [EXC_W-1:0]  exc_in,
    input  logic              bd_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              we_out,
    output logic [4:0]        wa_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic [EXC_W-1:0]  exc_out,
    output logic              bd_out,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              we;
        logic [4:0]        wa;
        logic [TNEW_W-1:0] tnew;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           entry_q, entry_d, load_entry;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Entry formed from the upstream inputs; an invalid input collapses to a NOP.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        load_entry = '0;
        if (valid_in) begin
            load_entry.valid = 1'b1;
            load_entry.data  = data_in;
            load_entry.we    = we_in && (wa_in != 5'd0) && (exc_in == '0);
            load_entry.wa    = wa_in;
            load_entry.exc   = exc_in;
            load_entry.bd    = bd_in;
            if (AGE_TNEW != 0) begin
                load_entry.tnew = (tnew_in == '0) ? '0 : tnew_in - 1'b1;
            end else begin
                load_entry.tnew = tnew_in;
            end
        end
    end

    // Priority below reset: flush > hold > bubble > load.
    always_comb begin
        entry_d      = entry_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush) begin
            entry_d = '0;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (hold) begin
            entry_d = entry_q;
        end else if (bubble) begin
            entry_d = '0;
            if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end else begin
            entry_d = load_entry;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            entry_q      <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            entry_q      <= entry_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign valid_out  = entry_q.valid;
    assign data_out   = entry_q.data;
    assign we_out     = entry_q.we;
    assign wa_out     = entry_q.wa;
    assign tnew_out   = entry_q.tnew;
    assign exc_out    = entry_q.exc;
    assign bd_out     = entry_q.bd;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default instance and one with
// AGE_TNEW = 0, CNT_W = 2, driven by the same stimulus.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset, hold, bubble, flush;
    logic         valid_in, we_in, bd_in;
    logic [127:0] data_in;
    logic [4:0]   wa_in, tnew_in, exc_in;

    logic         a_valid, a_we, a_bd;
    logic [127:0] a_data;
    logic [4:0]   a_wa, a_tnew, a_exc;
    logic [15:0]  a_bcnt, a_fcnt;

    logic         b_valid, b_we, b_bd;
    logic [127:0] b_data;
    logic [4:0]   b_wa, b_tnew, b_exc;
    logic [1:0]   b_bcnt, b_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .we_in(we_in), .wa_in(wa_in),
        .tnew_in(tnew_in), .exc_in(exc_in), .bd_in(bd_in),
        .valid_out(a_valid), .data_out(a_data), .we_out(a_we), .wa_out(a_wa),
        .tnew_out(a_tnew), .exc_out(a_exc), .bd_out(a_bd),
        .bubble_cnt(a_bcnt), .flush_cnt(a_fcnt)
    );

    pipe_stage_reg #(.AGE_TNEW(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .we_in(we_in), .wa_in(wa_in),
        .tnew_in(tnew_in), .exc_in(exc_in), .bd_in(bd_in),
        .valid_out(b_valid), .data_out(b_data), .we_out(b_we), .wa_out(b_wa),
        .tnew_out(b_tnew), .exc_out(b_exc), .bd_out(b_bd),
        .bubble_cnt(b_bcnt), .flush_cnt(b_fcnt)
    );

    typedef struct {
        logic         valid;
        logic [127:0] data;
        logic         we;
        logic [4:0]   wa;
        logic [4:0]   tnew_a;
        logic [4:0]   tnew_b;
        logic [4:0]   exc;
        logic         bd;
        int unsigned  bcnt_a, fcnt_a, bcnt_b, fcnt_b;
    } exp_t;

    exp_t m;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat_inc(int unsigned v, int unsigned max);
        return (v >= max) ? max : v + 1;
    endfunction

    function automatic exp_t clear_stage(exp_t s);
        exp_t n = s;
        n.valid = 0; n.data = '0; n.we = 0; n.wa = '0;
        n.tnew_a = '0; n.tnew_b = '0; n.exc = '0; n.bd = 0;
        return n;
    endfunction

    function automatic exp_t model_next(exp_t s);
        exp_t n = s;
        if (reset) begin
            n = clear_stage(s);
            n.bcnt_a = 0; n.fcnt_a = 0; n.bcnt_b = 0; n.fcnt_b = 0;
        end else if (flush) begin
            n = clear_stage(s);
            n.fcnt_a = sat_inc(s.fcnt_a, 65535);
            n.fcnt_b = sat_inc(s.fcnt_b, 3);
        end else if (hold) begin
            n = s;
        end else if (bubble) begin
            n = clear_stage(s);
            n.bcnt_a = sat_inc(s.bcnt_a, 65535);
            n.bcnt_b = sat_inc(s.bcnt_b, 3);
        end else begin
            n = clear_stage(s);
            if (valid_in) begin
                n.valid  = 1;
                n.data   = data_in;
                n.we     = we_in && (wa_in != 0) && (exc_in == 0);
                n.wa     = wa_in;
                n.exc    = exc_in;
                n.bd     = bd_in;
                n.tnew_a = (tnew_in == 0) ? 5'd0 : tnew_in - 5'd1;
                n.tnew_b = tnew_in;
            end
        end
        return n;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 128'(exp_q.size()), 128'(1));
            return;
        end
        e = exp_q.pop_front();
        check("a_valid", 128'(a_valid), 128'(e.valid));
        check("a_data",  a_data,        e.data);
        check("a_we",    128'(a_we),    128'(e.we));
        check("a_wa",    128'(a_wa),    128'(e.wa));
        check("a_tnew",  128'(a_tnew),  128'(e.tnew_a));
        check("a_exc",   128'(a_exc),   128'(e.exc));
        check("a_bd",    128'(a_bd),    128'(e.bd));
        check("a_bcnt",  128'(a_bcnt),  128'(e.bcnt_a));
        check("a_fcnt",  128'(a_fcnt),  128'(e.fcnt_a));
        check("b_valid", 128'(b_valid), 128'(e.valid));
        check("b_data",  b_data,        e.data);
        check("b_we",    128'(b_we),    128'(e.we));
        check("b_tnew",  128'(b_tnew),  128'(e.tnew_b));
        check("b_bcnt",  128'(b_bcnt),  128'(e.bcnt_b));
        check("b_fcnt",  128'(b_fcnt),  128'(e.fcnt_b));
    endtask

    // Push the expected entry for the current inputs, clock, then score it.
    task automatic step();
        m = model_next(m);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic set_ctrl(input logic r, input logic h, input logic b, input logic f);
        reset = r; hold = h; bubble = b; flush = f;
    endtask

    task automatic set_in(input logic v, input logic [127:0] d, input logic we,
                          input logic [4:0] wa, input logic [4:0] tn,
                          input logic [4:0] ex, input logic bd);
        valid_in = v; data_in = d; we_in = we; wa_in = wa;
        tnew_in = tn; exc_in = ex; bd_in = bd;
    endtask

    initial begin
        logic [1:0] sat_exp [6];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        m = '{default: '0};
        set_ctrl(1, 0, 0, 0);
        set_in(0, '0, 0, 0, 0, 0, 0);
        #1;
        step();
        step();
        check("reset_valid", 128'(a_valid), 128'(0));
        check("reset_bcnt",  128'(a_bcnt),  128'(0));

        // Reset while holding a valid entry
        set_ctrl(0, 0, 0, 0);
        set_in(1, 128'hDEADBEEF, 1, 5, 2, 0, 1);
        step();
        check("pre_reset_data", a_data, 128'hDEADBEEF);
        set_ctrl(1, 1, 0, 0);
        step();
        check("reset_hold_data",  a_data,        128'h0);
        check("reset_hold_we",    128'(a_we),    128'(0));
        check("reset_hold_fcnt",  128'(a_fcnt),  128'(0));

        // Load and tNew aging
        set_ctrl(0, 0, 0, 0);
        set_in(1, 128'h55, 1, 8, 2, 0, 0);
        step();
        check("load_we",     128'(a_we),   128'(1));
        check("load_wa",     128'(a_wa),   128'(8));
        check("age_tnew",    128'(a_tnew), 128'(1));
        check("noage_tnew",  128'(b_tnew), 128'(2));
        set_in(1, 128'h56, 1, 8, 0, 0, 0);
        step();
        check("age_tnew_zero", 128'(a_tnew), 128'(0));

        // Write squashing and invalid-input gating
        set_in(1, 128'h77, 1, 0, 3, 0, 0);
        step();
        check("squash_r0_we", 128'(a_we), 128'(0));
        set_in(1, 128'h78, 1, 9, 3, 4, 0);
        step();
        check("squash_exc_we", 128'(a_we),  128'(0));
        check("squash_exc",    128'(a_exc), 128'(4));
        set_in(0, 128'h1234, 1, 9, 3, 0, 1);
        step();
        check("invalid_data",  a_data,         128'h0);
        check("invalid_valid", 128'(a_valid),  128'(0));

        // Hold overrides bubble; bubble counted only when not frozen
        set_in(1, 128'hCAFE, 1, 12, 3, 0, 1);
        step();
        set_ctrl(0, 1, 1, 0);
        set_in(1, 128'hBAD, 1, 13, 4, 0, 0);
        repeat (3) step();
        check("hold_data",  a_data,        128'hCAFE);
        check("hold_tnew",  128'(a_tnew),  128'(2));
        check("hold_bcnt",  128'(a_bcnt),  128'(0));
        set_ctrl(0, 0, 1, 0);
        repeat (2) step();
        check("bubble_valid", 128'(a_valid), 128'(0));
        check("bubble_cnt2",  128'(a_bcnt),  128'(2));

        // Flush beats hold; back-to-back flushes each count
        set_ctrl(0, 0, 0, 0);
        set_in(1, 128'hF00D, 1, 3, 1, 0, 0);
        step();
        set_ctrl(0, 1, 0, 1);
        step();
        check("flush_valid", 128'(a_valid), 128'(0));
        check("flush_data",  a_data,        128'h0);
        check("flush_cnt1",  128'(a_fcnt),  128'(1));
        set_ctrl(0, 0, 0, 1);
        repeat (4) step();
        check("flush_cnt5",  128'(a_fcnt),  128'(5));
        check("flush_sat_b", 128'(b_fcnt),  128'(3));

        // Reset during flush clears everything; next edge is normal
        set_ctrl(1, 0, 0, 1);
        step();
        check("reset_flush_fcnt", 128'(a_fcnt), 128'(0));
        set_ctrl(0, 0, 0, 0);
        set_in(1, 128'hABC, 1, 7, 5, 0, 0);
        step();
        check("post_reset_load", a_data, 128'hABC);

        // Counter saturation on the CNT_W = 2 instance
        set_ctrl(1, 0, 0, 0);
        step();
        set_ctrl(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("sat_bcnt_%0d", i), 128'(b_bcnt), 128'(sat_exp[i]));
        end

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            set_ctrl($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) != 0,
                   {$urandom, $urandom, $urandom, $urandom},
                   1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   5'($urandom),
                   ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0,
                   1'($urandom));
            step();
        end

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
